// File: rtl/rx_link_if.sv
// Receive-link bundle between the link controller (master) and the Manchester datapath side (slave).
// Carries PLL status, decoded byte strobe, datapath reset, payload stream and statistics.
interface rx_link_if #(
    parameter int unsigned CNT_W = 16
);
    logic             pll_locked;
    logic             byte_valid;
    logic [7:0]       byte_in;
    logic             dp_resetn;
    logic             link_up;
    logic             data_valid;
    logic [7:0]       data_out;
    logic             sof;
    logic [CNT_W-1:0] sync_err_cnt;
    logic [CNT_W-1:0] relock_cnt;

    modport master (
        input  pll_locked, byte_valid, byte_in,
        output dp_resetn, link_up, data_valid, data_out, sof, sync_err_cnt, relock_cnt
    );

    modport slave (
        output pll_locked, byte_valid, byte_in,
        input  dp_resetn, link_up, data_valid, data_out, sof, sync_err_cnt, relock_cnt
    );
endinterface

// File: rtl/rx_link_controller.sv
// Sequences the Manchester receive datapath: waits for PLL lock, pulses the datapath reset,
// hunts for preamble/SFD, then forwards payload until a byte-gap timeout or PLL loss.
module rx_link_controller #(
    parameter logic [7:0]  SYNC_BYTE    = 8'h55,
    parameter logic [7:0]  SFD_BYTE     = 8'hD5,
    parameter int unsigned PREAMBLE_MIN = 4,
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned GAP_TIMEOUT  = 64,
    parameter int unsigned CNT_W        = 16
) (
    input logic       clk,
    input logic       areset,
    rx_link_if.master lnk
);
    localparam int unsigned PRE_W = $clog2(PREAMBLE_MIN + 1);
    localparam int unsigned RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned GAP_W = $clog2(GAP_TIMEOUT);

    localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);
    localparam logic [PRE_W-1:0] PRE_FULL = PRE_W'(PREAMBLE_MIN);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        RESET_DP,
        HUNT,
        LOCKED
    } state_t;

    state_t           state_q, state_d;
    logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             sof_arm_q, sof_arm_d;
    logic             dp_resetn_q, dp_resetn_d;
    logic             link_up_q, link_up_d;
    logic             data_valid_q, data_valid_d;
    logic             sof_q, sof_d;
    logic [7:0]       data_out_q, data_out_d;
    logic [CNT_W-1:0] sync_err_cnt_q, sync_err_cnt_d;
    logic [CNT_W-1:0] relock_cnt_q, relock_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_d        = state_q;
        rst_cnt_d      = rst_cnt_q;
        pre_cnt_d      = '0;
        gap_cnt_d      = gap_cnt_q;
        sof_arm_d      = sof_arm_q;
        data_valid_d   = 1'b0;
        sof_d          = 1'b0;
        data_out_d     = data_out_q;
        sync_err_cnt_d = sync_err_cnt_q;
        relock_cnt_d   = relock_cnt_q;

        // PLL loss overrides everything, including a byte arriving in the same cycle
        if (state_q != WAIT_LOCK && !lnk.pll_locked) begin
            state_d   = WAIT_LOCK;
            sof_arm_d = 1'b0;
            if (state_q == LOCKED) relock_cnt_d = sat_inc(relock_cnt_q);
        end else begin
            unique case (state_q)
                WAIT_LOCK: begin
                    if (lnk.pll_locked) begin
                        rst_cnt_d = RST_LOAD;
                        state_d   = RESET_DP;
                    end
                end
                RESET_DP: begin
                    if (rst_cnt_q == '0) state_d = HUNT;
                    else                 rst_cnt_d = rst_cnt_q - 1'b1;
                end
                HUNT: begin
                    pre_cnt_d = pre_cnt_q;
                    if (lnk.byte_valid) begin
                        if (lnk.byte_in == SYNC_BYTE) begin
                            if (pre_cnt_q != PRE_FULL) pre_cnt_d = pre_cnt_q + 1'b1;
                        end else if (lnk.byte_in == SFD_BYTE) begin
                            pre_cnt_d = '0;
                            if (pre_cnt_q == PRE_FULL) begin
                                state_d   = LOCKED;
                                gap_cnt_d = '0;
                                sof_arm_d = 1'b1;
                            end else begin
                                sync_err_cnt_d = sat_inc(sync_err_cnt_q);
                            end
                        end else begin
                            pre_cnt_d = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (lnk.byte_valid) begin
                        data_valid_d = 1'b1;
                        data_out_d   = lnk.byte_in;
                        sof_d        = sof_arm_q;
                        sof_arm_d    = 1'b0;
                        gap_cnt_d    = '0;
                    end else if (gap_cnt_q == GAP_LAST) begin
                        state_d      = RESET_DP;
                        rst_cnt_d    = RST_LOAD;
                        sof_arm_d    = 1'b0;
                        relock_cnt_d = sat_inc(relock_cnt_q);
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
                default: state_d = WAIT_LOCK;
            endcase
        end

        // Status outputs are registered against the state being entered
        dp_resetn_d = (state_d == HUNT) || (state_d == LOCKED);
        link_up_d   = (state_d == LOCKED);
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q        <= WAIT_LOCK;
            rst_cnt_q      <= '0;
            pre_cnt_q      <= '0;
            gap_cnt_q      <= '0;
            sof_arm_q      <= 1'b0;
            dp_resetn_q    <= 1'b0;
            link_up_q      <= 1'b0;
            data_valid_q   <= 1'b0;
            sof_q          <= 1'b0;
            data_out_q     <= '0;
            sync_err_cnt_q <= '0;
            relock_cnt_q   <= '0;
        end else begin
            state_q        <= state_d;
            rst_cnt_q      <= rst_cnt_d;
            pre_cnt_q      <= pre_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            sof_arm_q      <= sof_arm_d;
            dp_resetn_q    <= dp_resetn_d;
            link_up_q      <= link_up_d;
            data_valid_q   <= data_valid_d;
            sof_q          <= sof_d;
            data_out_q     <= data_out_d;
            sync_err_cnt_q <= sync_err_cnt_d;
            relock_cnt_q   <= relock_cnt_d;
        end
    end

    assign lnk.dp_resetn    = dp_resetn_q;
    assign lnk.link_up      = link_up_q;
    assign lnk.data_valid   = data_valid_q;
    assign lnk.sof          = sof_q;
    assign lnk.data_out     = data_out_q;
    assign lnk.sync_err_cnt = sync_err_cnt_q;
    assign lnk.relock_cnt   = relock_cnt_q;
endmodule

// File: tb/tb_rx_link_controller.sv
// Bench for rx_link_controller: directed scenarios plus randomized frames scored against
// expectations derived from preamble length, payload lists and teardown events.
module tb_rx_link_controller;
    logic clk = 1'b0;
    logic areset;
    int   checks = 0;
    int   failures = 0;

    int   exp_sync_err = 0;
    int   exp_relock = 0;
    bit   model_locked = 0;
    logic [8:0] obs_q[$];

    rx_link_if #(.CNT_W(16)) lnk ();
    rx_link_if #(.CNT_W(4))  lnk4 ();

    rx_link_controller #(.CNT_W(16)) dut (.clk(clk), .areset(areset), .lnk(lnk));
    rx_link_controller #(.PREAMBLE_MIN(4), .RST_CYCLES(2), .GAP_TIMEOUT(4), .CNT_W(4))
        dut4 (.clk(clk), .areset(areset), .lnk(lnk4));

    always #5 clk = ~clk;

    always @(negedge clk) if (lnk.data_valid === 1'b1) obs_q.push_back({lnk.sof, lnk.data_out});

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        lnk.byte_valid = 1'b1;
        lnk.byte_in    = b;
        @(negedge clk);
        lnk.byte_valid = 1'b0;
        lnk.byte_in    = 8'($urandom);
    endtask

    task automatic send4(input logic [7:0] b);
        lnk4.byte_valid = 1'b1;
        lnk4.byte_in    = b;
        @(negedge clk);
        lnk4.byte_valid = 1'b0;
    endtask

    task automatic wait_hunt(input string tag);
        int n = 0;
        while (lnk.dp_resetn !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (lnk.dp_resetn !== 1'b1) begin
            checks++; failures++;
            $display("FAIL %s_hunt_timeout dp_resetn=%b exp=1", tag, lnk.dp_resetn);
        end
    endtask

    task automatic lock_link();
        repeat (4) send(8'h55);
        send(8'hD5);
        model_locked = 1;
    endtask

    task automatic drop_relock();
        lnk.pll_locked = 1'b0;
        @(negedge clk);
        if (model_locked) exp_relock++;
        model_locked   = 0;
        lnk.pll_locked = 1'b1;
        wait_hunt("relock");
    endtask

    task automatic test_reset();
        idle(2);
        checks++; if (lnk.dp_resetn !== 1'b0) begin failures++; $display("FAIL rst_dp_resetn got=%b exp=0", lnk.dp_resetn); end
        checks++; if (lnk.link_up !== 1'b0) begin failures++; $display("FAIL rst_link_up got=%b exp=0", lnk.link_up); end
        checks++; if (lnk.data_valid !== 1'b0) begin failures++; $display("FAIL rst_data_valid got=%b exp=0", lnk.data_valid); end
        checks++; if (lnk.sof !== 1'b0) begin failures++; $display("FAIL rst_sof got=%b exp=0", lnk.sof); end
        checks++; if (lnk.data_out !== 8'h00) begin failures++; $display("FAIL rst_data_out got=%h exp=00", lnk.data_out); end
        checks++; if (lnk.sync_err_cnt !== 16'd0) begin failures++; $display("FAIL rst_sync_err got=%0d exp=0", lnk.sync_err_cnt); end
        checks++; if (lnk.relock_cnt !== 16'd0) begin failures++; $display("FAIL rst_relock got=%0d exp=0", lnk.relock_cnt); end
    endtask

    task automatic test_lock();
        int low = 0;
        bit link_seen = 0;
        areset = 1'b1;
        idle(1);
        areset = 1'b0;
        idle(5);
        lnk.pll_locked = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (lnk.link_up !== 1'b0) link_seen = 1;
            if (lnk.dp_resetn === 1'b0) low++;
            else break;
        end
        checks++; if (low != 16) begin failures++; $display("FAIL lock_dp_low_cycles got=%0d exp=16", low); end
        checks++; if (lnk.dp_resetn !== 1'b1) begin failures++; $display("FAIL lock_dp_release got=%b exp=1", lnk.dp_resetn); end
        checks++; if (link_seen) begin failures++; $display("FAIL lock_link_up_early got=1 exp=0"); end
    endtask

    task automatic test_frame();
        lock_link();
        checks++; if (lnk.link_up !== 1'b1) begin failures++; $display("FAIL frame_link_up got=%b exp=1", lnk.link_up); end
        send(8'hA1);
        checks++; if ({lnk.data_valid, lnk.sof, lnk.data_out} !== {1'b1, 1'b1, 8'hA1})
            begin failures++; $display("FAIL frame_first got dv=%b sof=%b d=%h exp dv=1 sof=1 d=a1", lnk.data_valid, lnk.sof, lnk.data_out); end
        send(8'hB2);
        checks++; if ({lnk.data_valid, lnk.sof, lnk.data_out} !== {1'b1, 1'b0, 8'hB2})
            begin failures++; $display("FAIL frame_second got dv=%b sof=%b d=%h exp dv=1 sof=0 d=b2", lnk.data_valid, lnk.sof, lnk.data_out); end
        idle(1);
        checks++; if ({lnk.data_valid, lnk.data_out} !== {1'b0, 8'hB2})
            begin failures++; $display("FAIL frame_hold got dv=%b d=%h exp dv=0 d=b2", lnk.data_valid, lnk.data_out); end
        drop_relock();
    endtask

    task automatic test_short_preamble();
        bit dv_seen = 0;
        send(8'h55); dv_seen |= lnk.data_valid;
        send(8'h55); dv_seen |= lnk.data_valid;
        send(8'hD5); dv_seen |= lnk.data_valid;
        exp_sync_err++;
        idle(2); dv_seen |= lnk.data_valid;
        checks++; if (lnk.sync_err_cnt !== 16'(exp_sync_err)) begin failures++; $display("FAIL short_sync_err got=%0d exp=%0d", lnk.sync_err_cnt, exp_sync_err); end
        checks++; if (lnk.link_up !== 1'b0) begin failures++; $display("FAIL short_link_up got=%b exp=0", lnk.link_up); end
        checks++; if (dv_seen) begin failures++; $display("FAIL short_data_valid got=1 exp=0"); end
        lock_link();
        checks++; if (lnk.link_up !== 1'b1) begin failures++; $display("FAIL short_relock got=%b exp=1", lnk.link_up); end
        drop_relock();
    endtask

    task automatic test_gap_timeout();
        int low = 1;
        lock_link();
        idle(63);
        send(8'h3C);
        checks++; if ({lnk.link_up, lnk.data_valid, lnk.data_out} !== {1'b1, 1'b1, 8'h3C})
            begin failures++; $display("FAIL gap_63_no_timeout got up=%b dv=%b d=%h exp up=1 dv=1 d=3c", lnk.link_up, lnk.data_valid, lnk.data_out); end
        idle(63);
        checks++; if (lnk.link_up !== 1'b1) begin failures++; $display("FAIL gap_before_timeout got=%b exp=1", lnk.link_up); end
        idle(1);
        exp_relock++;
        model_locked = 0;
        checks++; if (lnk.link_up !== 1'b0) begin failures++; $display("FAIL gap_timeout_link got=%b exp=0", lnk.link_up); end
        checks++; if (lnk.relock_cnt !== 16'(exp_relock)) begin failures++; $display("FAIL gap_relock got=%0d exp=%0d", lnk.relock_cnt, exp_relock); end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (lnk.dp_resetn === 1'b0) low++;
            else break;
        end
        checks++; if (low != 16) begin failures++; $display("FAIL gap_dp_low_cycles got=%0d exp=16", low); end
    endtask

    task automatic test_pll_loss();
        int low = 0;
        lock_link();
        send(8'h11);
        lnk.byte_valid = 1'b1;
        lnk.byte_in    = 8'h22;
        lnk.pll_locked = 1'b0;
        @(negedge clk);
        lnk.byte_valid = 1'b0;
        exp_relock++;
        model_locked = 0;
        checks++; if ({lnk.data_valid, lnk.dp_resetn, lnk.link_up, lnk.sof} !== 4'b0000)
            begin failures++; $display("FAIL pll_loss_outputs got dv/dp/up/sof=%b exp=0000", {lnk.data_valid, lnk.dp_resetn, lnk.link_up, lnk.sof}); end
        checks++; if (lnk.relock_cnt !== 16'(exp_relock)) begin failures++; $display("FAIL pll_loss_relock got=%0d exp=%0d", lnk.relock_cnt, exp_relock); end
        lnk.pll_locked = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (lnk.dp_resetn === 1'b0) low++;
            else break;
        end
        checks++; if (low != 16) begin failures++; $display("FAIL pll_relock_dp_low got=%0d exp=16", low); end
        lock_link();
        send(8'h33);
        checks++; if ({lnk.data_valid, lnk.sof, lnk.data_out} !== {1'b1, 1'b1, 8'h33})
            begin failures++; $display("FAIL pll_relock_sof got dv=%b sof=%b d=%h exp dv=1 sof=1 d=33", lnk.data_valid, lnk.sof, lnk.data_out); end
        drop_relock();
    endtask

    task automatic test_payload_alias();
        lock_link();
        send(8'hD5);
        checks++; if ({lnk.data_valid, lnk.sof, lnk.data_out} !== {1'b1, 1'b1, 8'hD5})
            begin failures++; $display("FAIL alias_sfd got dv=%b sof=%b d=%h exp dv=1 sof=1 d=d5", lnk.data_valid, lnk.sof, lnk.data_out); end
        send(8'h55);
        checks++; if ({lnk.data_valid, lnk.sof, lnk.data_out, lnk.link_up} !== {1'b1, 1'b0, 8'h55, 1'b1})
            begin failures++; $display("FAIL alias_sync got dv=%b sof=%b d=%h up=%b exp dv=1 sof=0 d=55 up=1", lnk.data_valid, lnk.sof, lnk.data_out, lnk.link_up); end
        checks++; if (lnk.sync_err_cnt !== 16'(exp_sync_err)) begin failures++; $display("FAIL alias_sync_err got=%0d exp=%0d", lnk.sync_err_cnt, exp_sync_err); end
        drop_relock();
    endtask

    task automatic test_async_reset();
        bit dv_seen = 0;
        lock_link();
        send(8'h77);
        lnk.byte_valid = 1'b1;
        lnk.byte_in    = 8'h88;
        #2 areset = 1'b1;
        #1;
        checks++; if ({lnk.link_up, lnk.dp_resetn, lnk.data_valid, lnk.sof, lnk.data_out} !== 12'h000)
            begin failures++; $display("FAIL areset_async got up=%b dp=%b dv=%b sof=%b d=%h exp all 0", lnk.link_up, lnk.dp_resetn, lnk.data_valid, lnk.sof, lnk.data_out); end
        checks++; if ({lnk.sync_err_cnt, lnk.relock_cnt} !== 32'h0)
            begin failures++; $display("FAIL areset_counters got se=%0d rl=%0d exp 0 0", lnk.sync_err_cnt, lnk.relock_cnt); end
        @(negedge clk);
        lnk.byte_valid = 1'b0;
        @(negedge clk);
        areset = 1'b0;
        exp_sync_err = 0;
        exp_relock   = 0;
        model_locked = 0;
        repeat (20) begin
            @(negedge clk);
            dv_seen |= lnk.data_valid;
        end
        checks++; if (dv_seen) begin failures++; $display("FAIL areset_partial_byte got dv=1 exp=0"); end
        wait_hunt("areset");
    endtask

    task automatic test_random();
        logic [8:0] exp_q[$];
        logic [7:0] b;
        int k, n;
        bit bad;
        for (int f = 0; f < 12; f++) begin
            obs_q.delete();
            exp_q.delete();
            repeat ($urandom_range(0, 3)) begin
                do b = 8'($urandom); while (b == 8'h55 || b == 8'hD5);
                send(b);
                idle($urandom_range(0, 2));
            end
            k = $urandom_range(0, 6);
            repeat (k) begin
                send(8'h55);
                idle($urandom_range(0, 2));
            end
            send(8'hD5);
            if (k >= 4) begin
                model_locked = 1;
                n = $urandom_range(1, 6);
                for (int j = 0; j < n; j++) begin
                    idle($urandom_range(0, 4));
                    b = 8'($urandom);
                    exp_q.push_back({(j == 0), b});
                    send(b);
                end
                if ($urandom_range(0, 1) == 1) begin
                    idle(70);
                    exp_relock++;
                    model_locked = 0;
                    wait_hunt("rand_timeout");
                end else begin
                    idle(1);
                    drop_relock();
                end
            end else begin
                exp_sync_err++;
            end
            idle(2);
            bad = (obs_q.size() != exp_q.size());
            if (!bad) foreach (exp_q[j]) if (obs_q[j] !== exp_q[j]) bad = 1;
            checks++; if (bad) begin failures++; $display("FAIL rand_payload frame=%0d got_n=%0d exp_n=%0d", f, obs_q.size(), exp_q.size()); end
            checks++; if (lnk.sync_err_cnt !== 16'(exp_sync_err)) begin failures++; $display("FAIL rand_sync_err frame=%0d got=%0d exp=%0d", f, lnk.sync_err_cnt, exp_sync_err); end
            checks++; if (lnk.relock_cnt !== 16'(exp_relock)) begin failures++; $display("FAIL rand_relock frame=%0d got=%0d exp=%0d", f, lnk.relock_cnt, exp_relock); end
        end
    endtask

    task automatic test_saturation();
        int n;
        int exp_sat;
        for (int i = 1; i <= 17; i++) begin
            lnk4.pll_locked = 1'b1;
            n = 0;
            while (lnk4.dp_resetn !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (lnk4.dp_resetn !== 1'b1) begin checks++; failures++; $display("FAIL sat_hunt_timeout iter=%0d", i); end
            send4(8'h55); send4(8'h55); send4(8'hD5);
            repeat (4) send4(8'h55);
            send4(8'hD5);
            lnk4.pll_locked = 1'b0;
            @(negedge clk);
            exp_sat = (i < 15) ? i : 15;
            checks++; if (lnk4.relock_cnt !== 4'(exp_sat)) begin failures++; $display("FAIL sat_relock iter=%0d got=%0d exp=%0d", i, lnk4.relock_cnt, exp_sat); end
            checks++; if (lnk4.sync_err_cnt !== 4'(exp_sat)) begin failures++; $display("FAIL sat_sync_err iter=%0d got=%0d exp=%0d", i, lnk4.sync_err_cnt, exp_sat); end
        end
    endtask

    initial begin
        areset          = 1'b1;
        lnk.pll_locked  = 1'b0;
        lnk.byte_valid  = 1'b0;
        lnk.byte_in     = 8'h00;
        lnk4.pll_locked = 1'b0;
        lnk4.byte_valid = 1'b0;
        lnk4.byte_in    = 8'h00;
        test_reset();
        test_lock();
        test_frame();
        test_short_preamble();
        test_gap_timeout();
        test_pll_loss();
        test_payload_alias();
        test_async_reset();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
